// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - N-channel colour-dispense sequencer with car travel and return-to-home
// Optional: define CONTINUOUS_CYCLE_EN to let a start seen in DONE chain straight into a new sequence.
module dispense_sequencer #(
  parameter int N_CH     = 3,
  parameter int DEPTH    = 24,
  parameter int CAR_TIME = 7,
  parameter int CNT_W    = 10,
  parameter int CH_W     = 3
) (
  input  logic                  clk_cnt,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_CH*CNT_W-1:0] freq_vec,
  output logic [N_CH-1:0]       ch_en,
  output logic                  motor_dir,
  output logic                  car_en,
  output logic                  car_dir,
  output logic                  busy,
  output logic                  done,
  output logic [CH_W-1:0]       ch_idx,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPENSE = 3'd1,
    S_TRAVEL   = 3'd2,
    S_RETURN   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam int HOP     = CAR_TIME + 1;
  localparam int RET_MAX = N_CH * HOP;
  // sec doubles as stroke, hop and return-leg counter, so it must hold the largest of them
  localparam int SEC_MAX = (2 * DEPTH > RET_MAX) ? 2 * DEPTH : RET_MAX;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);

  state_t                  state_q;
  logic [CH_W-1:0]         ch_idx_q;
  logic [SEC_W-1:0]        sec_q;
  logic [SEC_W-1:0]        ret_len_q;
  logic [CNT_W-1:0]        rnd_q;
  logic [N_CH*CNT_W-1:0]   freq_q;

  logic [CNT_W-1:0]        cur_cnt;
  logic                    dispensing;
  logic [SEC_W-1:0]        ret_disp;
  logic [SEC_W-1:0]        ret_trav;

  always_comb begin
    cur_cnt = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_idx_q == CH_W'(k)) cur_cnt = freq_q[k*CNT_W +: CNT_W];
    end
  end

  assign dispensing = (state_q == S_DISPENSE) && (rnd_q < cur_cnt);

  // Aborting mid-hop overruns by one extra hop so the car lands hard on the home end-stop.
  assign ret_disp = SEC_W'(32'(ch_idx_q) * 32'(HOP));
  assign ret_trav = SEC_W'((32'(ch_idx_q) + 32'd1) * 32'(HOP));

  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_idx_q  <= '0;
      sec_q     <= '0;
      rnd_q     <= '0;
      ret_len_q <= '0;
      freq_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            freq_q   <= freq_vec;
            ch_idx_q <= '0;
            sec_q    <= '0;
            rnd_q    <= '0;
            state_q  <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          if (abort || (rnd_q >= cur_cnt)) begin
            sec_q <= '0;
            rnd_q <= '0;
            if (!abort && (ch_idx_q < CH_W'(N_CH - 1))) begin
              state_q <= S_TRAVEL;
            end else if (ret_disp == '0) begin
              state_q <= S_DONE;
            end else begin
              ret_len_q <= ret_disp;
              state_q   <= S_RETURN;
            end
          end else if (sec_q == SEC_W'(2 * DEPTH)) begin
            sec_q <= '0;
            rnd_q <= rnd_q + CNT_W'(1);
          end else begin
            sec_q <= sec_q + SEC_W'(1);
          end
        end
        S_TRAVEL: begin
          if (abort) begin
            sec_q     <= '0;
            ret_len_q <= ret_trav;
            state_q   <= S_RETURN;
          end else if (sec_q == SEC_W'(CAR_TIME)) begin
            sec_q    <= '0;
            ch_idx_q <= ch_idx_q + CH_W'(1);
            state_q  <= S_DISPENSE;
          end else begin
            sec_q <= sec_q + SEC_W'(1);
          end
        end
        S_RETURN: begin
          if ((sec_q + SEC_W'(1)) >= ret_len_q) begin
            sec_q   <= '0;
            state_q <= S_DONE;
          end else begin
            sec_q <= sec_q + SEC_W'(1);
          end
        end
        S_DONE: begin
`ifdef CONTINUOUS_CYCLE_EN
          if (start) begin
            freq_q   <= freq_vec;
            ch_idx_q <= '0;
            sec_q    <= '0;
            rnd_q    <= '0;
            state_q  <= S_DISPENSE;
          end else begin
            ch_idx_q <= '0;
            state_q  <= S_IDLE;
          end
`else
          ch_idx_q <= '0;
          state_q  <= S_IDLE;
`endif
        end
        default: begin
          state_q  <= S_IDLE;
          ch_idx_q <= '0;
          sec_q    <= '0;
          rnd_q    <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ch_en = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_en[k] = dispensing && (ch_idx_q == CH_W'(k));
    end
  end

  assign motor_dir = dispensing && (sec_q > SEC_W'(DEPTH));
  assign car_en    = (state_q == S_TRAVEL) || (state_q == S_RETURN);
  assign car_dir   = (state_q == S_TRAVEL);
  assign busy      = (state_q == S_DISPENSE) || (state_q == S_TRAVEL) || (state_q == S_RETURN);
  assign done      = (state_q == S_DONE);
  assign ch_idx    = ch_idx_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - randomized bench with a tick-sequence model of dispense_sequencer
module tb_dispense_sequencer;

  localparam int N_CH     = 3;
  localparam int DEPTH    = 4;
  localparam int CAR_TIME = 2;
  localparam int CNT_W    = 10;
  localparam int CH_W     = 2;
  localparam int HOP      = CAR_TIME + 1;
  localparam int FW       = N_CH * CNT_W;

  typedef struct packed {
    logic [2:0]      st;
    logic [N_CH-1:0] en;
    logic            mdir;
    logic            cen;
    logic            cdir;
    logic            bsy;
    logic            dn;
    logic [CH_W-1:0] ch;
  } tick_t;

  logic            clk_cnt;
  logic            rst;
  logic            start;
  logic            abort;
  logic [FW-1:0]   freq_vec;
  logic [N_CH-1:0] ch_en;
  logic            motor_dir;
  logic            car_en;
  logic            car_dir;
  logic            busy;
  logic            done;
  logic [CH_W-1:0] ch_idx;
  logic [2:0]      state_o;

  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 0;
  int    fr[N_CH];
  tick_t seq[$];
  tick_t exp_q[$];
  tick_t idle_t = '0;
  tick_t e_t;
  tick_t a_t;
  int    n_busy, n_mdir, n_ret, n_en010;

  dispense_sequencer #(
    .N_CH(N_CH), .DEPTH(DEPTH), .CAR_TIME(CAR_TIME), .CNT_W(CNT_W), .CH_W(CH_W)
  ) dut (
    .clk_cnt(clk_cnt), .rst(rst), .start(start), .abort(abort), .freq_vec(freq_vec),
    .ch_en(ch_en), .motor_dir(motor_dir), .car_en(car_en), .car_dir(car_dir),
    .busy(busy), .done(done), .ch_idx(ch_idx), .state_o(state_o)
  );

  initial clk_cnt = 0;
  always #5 clk_cnt = ~clk_cnt;

  task automatic expect_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int st, input int c, input bit en, input bit md);
    tick_t t;
    t.st   = 3'(st);
    t.en   = en ? N_CH'(1 << c) : '0;
    t.mdir = md;
    t.cen  = (st == 2) || (st == 3);
    t.cdir = (st == 2);
    t.bsy  = (st >= 1) && (st <= 3);
    t.dn   = (st == 4);
    t.ch   = CH_W'(c);
    seq.push_back(t);
  endtask

  // Expands a whole recipe into the tick-by-tick output sequence; ab is the sequence tick carrying abort.
  task automatic build(input int ab);
    int t = 0;
    bit stop = 0;
    int ret = 0;
    int last_ch = 0;
    for (int c = 0; c < N_CH && !stop; c++) begin
      last_ch = c;
      for (int r = 0; r < fr[c] && !stop; r++) begin
        for (int s = 0; s <= 2 * DEPTH && !stop; s++) begin
          push(1, c, 1, s > DEPTH);
          if (t == ab) begin stop = 1; ret = c * HOP; end
          t++;
        end
      end
      if (!stop) begin
        push(1, c, 0, 0);
        if (t == ab || c == N_CH - 1) begin stop = 1; ret = c * HOP; end
        t++;
      end
      for (int s = 0; s < HOP && !stop; s++) begin
        push(2, c, 0, 0);
        if (t == ab) begin stop = 1; ret = (c + 1) * HOP; end
        t++;
      end
    end
    for (int k = 0; k < ret; k++) push(3, last_ch, 0, 0);
    push(4, last_ch, 0, 0);
  endtask

  task automatic drive_freq();
    for (int j = 0; j < N_CH; j++) freq_vec[j*CNT_W +: CNT_W] = CNT_W'(fr[j]);
  endtask

  task automatic set_fr(input int a, input int b, input int c);
    fr[0] = a; fr[1] = b; fr[2] = c;
  endtask

  always @(negedge clk_cnt) begin
    if (chk_en) begin
      e_t = (exp_q.size() > 0) ? exp_q.pop_front() : idle_t;
      a_t = {state_o, ch_en, motor_dir, car_en, car_dir, busy, done, ch_idx};
      checks++;
      if (a_t !== e_t) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, a_t, e_t);
      end
      if (busy) n_busy++;
      if (motor_dir) n_mdir++;
      if (state_o == 3'd3) n_ret++;
      if (ch_en == 3'b010) n_en010++;
    end
  end

  task automatic run(input int ab, input bit hold, input int rst_at);
    int  n1;
    int  k;
    bit  did_rst = 0;
    seq.delete();
    build(ab);
    n1 = seq.size();
    @(posedge clk_cnt); #1;
    drive_freq();
    start = 1;
    abort = 0;
    n_busy = 0; n_mdir = 0; n_ret = 0; n_en010 = 0;
    exp_q.push_back(idle_t);
    foreach (seq[j]) exp_q.push_back(seq[j]);
    for (int i = 1; i <= seq.size(); i++) begin
      @(posedge clk_cnt); #1;
      k = i - 1;
      if (k == rst_at) begin
        expect_eq("pre_rst_state", int'(state_o), 2);
        #2;
        chk_en = 0;
        rst = 1;
        #1;
        expect_eq("rst_async_outputs", int'({ch_en, motor_dir, car_en, car_dir, busy, done, ch_idx}), 0);
        expect_eq("rst_async_state", int'(state_o), 0);
        exp_q.delete();
        @(posedge clk_cnt); #1;
        rst = 0; start = 0; abort = 0; chk_en = 1;
        did_rst = 1;
        break;
      end
      if (hold) start = (k < n1);
      else start = (seq[k].st inside {3'd1, 3'd2, 3'd3}) ? 1'($urandom % 2) : 1'b0;
      abort = (k == ab) || ((seq[k].st >= 3'd3) && (($urandom % 2) == 1));
      if (hold && k == 1) begin
        for (int j = 0; j < N_CH; j++) fr[j] = int'($urandom_range(2, 0));
        drive_freq();
`ifdef CONTINUOUS_CYCLE_EN
        build(-1);
        for (int j = n1; j < seq.size(); j++) exp_q.push_back(seq[j]);
`endif
      end else if (!hold && ($urandom % 4) == 0) begin
        freq_vec = FW'($urandom);
      end
    end
    if (!did_rst) begin
      @(posedge clk_cnt); #1;
      start = 0;
      abort = 0;
    end
  endtask

  initial begin
    int nb;
    int ab;
    rst = 1; start = 0; abort = 0; freq_vec = '0;
    repeat (2) @(posedge clk_cnt);
    #1;
    expect_eq("reset_state", int'(state_o), 0);
    expect_eq("reset_outputs", int'({ch_en, motor_dir, car_en, car_dir, busy, done, ch_idx}), 0);
    rst = 0;
    chk_en = 1;

    set_fr(1, 1, 1);
    run(-1, 0, -1);
    expect_eq("t1_model_len", seq.size(), 43);
    expect_eq("t1_busy_ticks", n_busy, 42);
    expect_eq("t1_up_ticks", n_mdir, 12);
    expect_eq("t1_return_ticks", n_ret, 6);

    set_fr(0, 2, 0);
    run(-1, 0, -1);
    expect_eq("t2_ch1_en_ticks", n_en010, 18);
    expect_eq("t2_busy_ticks", n_busy, 33);

    set_fr(3, 3, 3);
    run(34, 0, -1);
    expect_eq("t3_abort_return", n_ret, 3);

    set_fr(1, 1, 1);
    run(11, 0, -1);
    expect_eq("t4_travel_abort_return", n_ret, 3);
    run(0, 0, -1);
    expect_eq("t4_ch0_abort_return", n_ret, 0);
    expect_eq("t4_ch0_abort_busy", n_busy, 1);

    run(-1, 0, 11);
    set_fr(2, 1, 0);
    run(-1, 1, -1);

    for (int r = 0; r < 25; r++) begin
      for (int j = 0; j < N_CH; j++) fr[j] = int'($urandom_range(3, 0));
      seq.delete();
      build(-1);
      nb = 0;
      foreach (seq[j]) if (seq[j].st == 3'd1 || seq[j].st == 3'd2) nb++;
      ab = (($urandom % 3) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      run(ab, 0, -1);
    end

    repeat (3) @(posedge clk_cnt);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Parametrised N-channel colour-dispense sequencer.
- Drives the per-channel stepper enables and the shared stepper direction, then moves the car between stations and back to home.
- Adds what the fixed 3-colour controller lacked: start/busy/done handshake, abort with return-to-home, skipping of zero-count channels, and latched per-channel round counts.
- Sits between the colour/recipe logic and the stepper/servo drivers. Ticks on the slow count clock.

Parameters:
- N_CH, 3, number of dispense channels/stations (1..8).
- DEPTH, 24, half-stroke length in ticks; one round = 2*DEPTH+1 ticks.
- CAR_TIME, 7, ticks per single-station hop = CAR_TIME+1.
- CNT_W, 10, width of each per-channel round count.
- CH_W, 3, width of the channel index (>= clog2(N_CH), min 1).

Ports:
- clk_cnt  in  1  slow tick clock; all state advances on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sequence; sampled only in IDLE.
- abort  in  1  synchronous abort; honoured in DISPENSE/TRAVEL only.
- freq_vec  in  N_CH*CNT_W  round count per channel, ch k at bits [k*CNT_W +: CNT_W]; latched on start.
- ch_en  out  N_CH  one-hot stepper enable for the active channel.
- motor_dir  out  1  stepper direction: 0 = down stroke, 1 = up stroke.
- car_en  out  1  car servo enable.
- car_dir  out  1  1 = outbound to the next station, 0 = return home.
- busy  out  1  high in DISPENSE/TRAVEL/RETURN.
- done  out  1  one-tick completion pulse.
- ch_idx  out  CH_W  current channel.
- state_o  out  3  encoded FSM state: IDLE=0, DISPENSE=1, TRAVEL=2, RETURN=3, DONE=4.

Behaviour:
- Reset (async): state IDLE; ch_idx, sec, rnd and the latched counts are 0. Every output is 0.
- Outputs are decoded from registered state and counters. No extra pipeline latency.
- IDLE:
  - start=1 → latch freq_vec; ch_idx=0, sec=0, rnd=0; next state DISPENSE.
  - Otherwise hold.
- DISPENSE (cnt = latched count of ch_idx):
  - If rnd<cnt: ch_en[ch_idx]=1 and motor_dir=(sec>DEPTH).
  - sec counts 0..2*DEPTH. At sec==2*DEPTH: sec←0, rnd←rnd+1.
  - If rnd==cnt: ch_en=0, motor_dir=0, and the tick exits. Exit is to TRAVEL if ch_idx<N_CH-1, else RETURN. sec and rnd are cleared.
  - cnt=0 gives a single exit tick with no enable (channel skipped).
- TRAVEL:
  - car_en=1, car_dir=1. sec counts 0..CAR_TIME.
  - At sec==CAR_TIME: ch_idx+1, sec←0, next state DISPENSE.
- RETURN:
  - car_en=1, car_dir=0.
  - Duration = ret_len ticks, with ret_len loaded on entry:
    - ch_idx*(CAR_TIME+1) from DISPENSE;
    - (ch_idx+1)*(CAR_TIME+1) when aborting from TRAVEL (deliberate overrun onto the end-stop).
  - ret_len=0 → go straight to DONE; RETURN is not entered.
- DONE: done=1 for one tick, then IDLE. ch_idx is cleared.
- abort:
  - In DISPENSE or TRAVEL: next tick is RETURN with ch_en=0. Abort takes priority over a normal exit in the same tick.
  - Ignored in IDLE/RETURN/DONE.
- start outside IDLE is ignored. freq_vec changes after the latch have no effect.
- Counter widths must hold 2*DEPTH and N_CH*(CAR_TIME+1) without wrap.
- Illegal state → IDLE on the next tick.

Optional Feature:
- Macro CONTINUOUS_CYCLE_EN.
- Defined: in DONE, if start=1, re-latch freq_vec and go directly to DISPENSE with ch_idx=0. No IDLE tick; done still pulses.
- Undefined: DONE always goes to IDLE, and a new start needs at least one IDLE tick.

Test Plan (N_CH=3, DEPTH=4, CAR_TIME=2, CNT_W=10):
1. freq={1,1,1}, pulse start:
   - ch0: ch_en=001 for 9 ticks, with motor_dir 0 for 5 ticks then 1 for 4; then 1 exit tick.
   - Then TRAVEL 3 ticks with car_dir=1, repeated per channel.
   - RETURN 6 ticks with car_dir=0, then done for 1 tick.
   - busy high 42 ticks in total.
2. freq={0,2,0}:
   - ch0 1 tick with ch_en=000, TRAVEL 3.
   - ch1 ch_en=010 for 18 ticks + 1 exit, TRAVEL 3.
   - ch2 1 tick, RETURN 6, done.
3. freq={3,3,3}, abort on the 4th DISPENSE tick of ch1 → next tick RETURN, car_en=1 for exactly 3 ticks, then done, then IDLE.
4. abort in the 2nd TRAVEL tick from ch0 → RETURN for 3 ticks. Abort on tick 1 of ch0 DISPENSE → DONE next tick, no RETURN.
5. rst asserted mid-TRAVEL → all outputs 0 and state_o=0 immediately, with no clock edge needed. start held high while busy, and freq_vec changed mid-run → no restart, original counts used.
6. With CONTINUOUS_CYCLE_EN, start held high through DONE → DISPENSE ch0 on the following tick. Without the macro → state_o=0 for that tick.
